// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for a WIDTH-bit bit-slice ALU: accepts ops over valid/ready,
// drives ALU controls/operands, runs MUL as a shift-add loop, returns results over valid/ready.
module alu_seq_ctrl #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned MUL_STEPS = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_result,
   output logic             resp_err,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_operation,
   output logic             alu_binvert,
   output logic             alu_cin,
   input  logic [WIDTH-1:0] alu_result
);

   localparam int unsigned CW = $clog2(MUL_STEPS + 1);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_ILL = 3'b111;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_LESS = 3'b001;
   localparam logic [2:0] ALU_OR   = 3'b010;
   localparam logic [2:0] ALU_XOR  = 3'b011;
   localparam logic [2:0] ALU_ADD  = 3'b100;

   typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  q_q, q_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              req_ready_d, resp_valid_d, resp_err_d;
   logic [WIDTH-1:0]  resp_result_d, alu_a_d, alu_b_d, mul_p;
   logic [2:0]        alu_operation_d;
   logic              alu_binvert_d, alu_cin_d;

   // {operation, binvert, cin} for the single-cycle ops
   function automatic logic [4:0] exec_ctrl(input logic [2:0] op);
      case (op)
         OP_AND:  exec_ctrl = {ALU_AND,  2'b00};
         OP_OR:   exec_ctrl = {ALU_OR,   2'b00};
         OP_XOR:  exec_ctrl = {ALU_XOR,  2'b00};
         OP_ADD:  exec_ctrl = {ALU_ADD,  2'b00};
         OP_SUB:  exec_ctrl = {ALU_ADD,  2'b11};
         OP_SLT:  exec_ctrl = {ALU_LESS, 2'b11};
         default: exec_ctrl = 5'b0;
      endcase
   endfunction

   // During MUL, alu_a holds the partial product P and alu_b the shifted multiplicand M
   assign mul_p = q_q[0] ? alu_result : alu_a;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         q_q           <= '0;
         cnt_q         <= '0;
         req_ready     <= 1'b0;
         resp_valid    <= 1'b0;
         resp_result   <= '0;
         resp_err      <= 1'b0;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_operation <= 3'b000;
         alu_binvert   <= 1'b0;
         alu_cin       <= 1'b0;
      end else begin
         state_q       <= state_d;
         q_q           <= q_d;
         cnt_q         <= cnt_d;
         req_ready     <= req_ready_d;
         resp_valid    <= resp_valid_d;
         resp_result   <= resp_result_d;
         resp_err      <= resp_err_d;
         alu_a         <= alu_a_d;
         alu_b         <= alu_b_d;
         alu_operation <= alu_operation_d;
         alu_binvert   <= alu_binvert_d;
         alu_cin       <= alu_cin_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      q_d             = q_q;
      cnt_d           = cnt_q;
      resp_valid_d    = resp_valid;
      resp_result_d   = resp_result;
      resp_err_d      = resp_err;
      alu_a_d         = alu_a;
      alu_b_d         = alu_b;
      alu_operation_d = alu_operation;
      alu_binvert_d   = alu_binvert;
      alu_cin_d       = alu_cin;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               if (req_op == OP_MUL) begin
                  alu_a_d         = '0;
                  alu_b_d         = req_a;
                  q_d             = req_b;
                  cnt_d           = CW'(MUL_STEPS);
                  alu_operation_d = ALU_ADD;
                  alu_binvert_d   = 1'b0;
                  alu_cin_d       = 1'b0;
                  state_d         = MUL;
               end else if (req_op == OP_ILL) begin
                  resp_result_d = '0;
                  resp_err_d    = 1'b1;
                  resp_valid_d  = 1'b1;
                  state_d       = RESP;
               end else begin
                  alu_a_d = req_a;
                  alu_b_d = req_b;
                  {alu_operation_d, alu_binvert_d, alu_cin_d} = exec_ctrl(req_op);
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            resp_result_d   = alu_result;
            resp_valid_d    = 1'b1;
            alu_a_d         = '0;
            alu_b_d         = '0;
            alu_operation_d = 3'b000;
            alu_binvert_d   = 1'b0;
            alu_cin_d       = 1'b0;
            state_d         = RESP;
         end
         MUL: begin
            alu_a_d = mul_p;
            alu_b_d = alu_b << 1;
            q_d     = q_q >> 1;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               resp_result_d   = mul_p;
               resp_valid_d    = 1'b1;
               alu_a_d         = '0;
               alu_b_d         = '0;
               alu_operation_d = 3'b000;
               alu_binvert_d   = 1'b0;
               alu_cin_d       = 1'b0;
               state_d         = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Registered ready: high exactly in IDLE, no combinational bypass
      req_ready_d = (state_d == IDLE);
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural slice-ALU model and a response scoreboard.
module tb_alu_seq_ctrl;

   localparam int unsigned WIDTH = 16;

   logic             clk, rst;
   logic             req_valid, req_ready, resp_valid, resp_ready, resp_err;
   logic [2:0]       req_op, alu_operation;
   logic [WIDTH-1:0] req_a, req_b, resp_result, alu_a, alu_b, alu_result;
   logic             alu_binvert, alu_cin;
   logic [WIDTH-1:0] bb, sum;

   int n_vec  = 0;
   int n_fail = 0;
   logic [WIDTH:0] sb[$];

   alu_seq_ctrl #(.WIDTH(WIDTH), .MUL_STEPS(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_err(resp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
      .alu_binvert(alu_binvert), .alu_cin(alu_cin), .alu_result(alu_result)
   );

   // Behavioural 1-bit-slice ALU: Less feeds the adder sign bit into slice 0
   always_comb begin
      bb  = alu_binvert ? ~alu_b : alu_b;
      sum = alu_a + bb + WIDTH'(alu_cin);
      case (alu_operation)
         3'b000:  alu_result = alu_a & bb;
         3'b001:  alu_result = WIDTH'(sum[WIDTH-1]);
         3'b010:  alu_result = alu_a | bb;
         3'b011:  alu_result = alu_a ^ bb;
         3'b100:  alu_result = sum;
         default: alu_result = '0;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] alu_bus();
      return 64'({alu_operation, alu_binvert, alu_cin, alu_a, alu_b});
   endfunction

   task automatic wait_ready(input string tag);
      int w = 0;
      while (req_ready !== 1'b1 && w < 10) begin
         tick();
         w++;
      end
      chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
   endtask

   // Issue one request, check first-cycle ALU drive, latency and the scoreboarded response
   task automatic run_op(input string tag, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] res, input logic err, input int lat_exp,
                         input logic [2:0] e_op, input logic e_binv, input logic e_cin,
                         input logic [WIDTH-1:0] e_a, input logic [WIDTH-1:0] e_b,
                         input bit ack);
      int lat;
      logic [WIDTH:0] exp;
      wait_ready(tag);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      sb.push_back({err, res});
      tick();
      req_valid = 1'b0;
      req_a     = WIDTH'($urandom);
      req_b     = WIDTH'($urandom);
      chk({tag, "_alu_first"}, alu_bus(), 64'({e_op, e_binv, e_cin, e_a, e_b}));
      chk({tag, "_busy_ready"}, 64'(req_ready), 64'd0);
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
         chk({tag, "_busy_ready"}, 64'(req_ready), 64'd0);
      end
      chk({tag, "_latency"}, 64'(lat), 64'(lat_exp));
      if (sb.size() == 0) begin
         n_vec++;
         n_fail++;
         $error("FAIL %s_sb: observed response expected none queued", tag);
      end else begin
         exp = sb.pop_front();
         chk({tag, "_result"}, 64'(resp_result), 64'(exp[WIDTH-1:0]));
         chk({tag, "_err"}, 64'(resp_err), 64'(exp[WIDTH]));
      end
      chk({tag, "_alu_idle"}, alu_bus(), 64'd0);
      if (ack) begin
         tick();
         chk({tag, "_post_valid"}, 64'(resp_valid), 64'd0);
         chk({tag, "_post_ready"}, 64'(req_ready), 64'd1);
         chk({tag, "_post_err"}, 64'(resp_err), 64'd0);
         chk({tag, "_post_result"}, 64'(resp_result), 64'(res));
      end
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_op     = 3'b000;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b1;
      tick();
      tick();
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp", 64'({resp_err, resp_result}), 64'd0);
      chk("rst_alu", alu_bus(), 64'd0);
      rst = 1'b0;
      tick();
      chk("rst_release_ready", 64'(req_ready), 64'd1);

      run_op("add", 3'b011, 16'h1234, 16'h0FF0, 16'h2224, 1'b0, 1, 3'b100, 1'b0, 1'b0, 16'h1234, 16'h0FF0, 1'b1);
      run_op("sub", 3'b100, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1, 3'b100, 1'b1, 1'b1, 16'h0005, 16'h0007, 1'b1);
      run_op("slt", 3'b101, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1, 3'b001, 1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b1);
      run_op("or",  3'b001, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1, 3'b010, 1'b0, 1'b0, 16'hF000, 16'h000F, 1'b1);
      run_op("mul", 3'b110, 16'h0013, 16'h0011, 16'h0143, 1'b0, 16, 3'b100, 1'b0, 1'b0, 16'h0000, 16'h0013, 1'b1);
      run_op("mul_ovf", 3'b110, 16'h0100, 16'h0100, 16'h0000, 1'b0, 16, 3'b100, 1'b0, 1'b0, 16'h0000, 16'h0100, 1'b1);
      run_op("mul_big", 3'b110, 16'hFFFF, 16'h8001, 16'h7FFF, 1'b0, 16, 3'b100, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1);

      // Backpressure: response must hold while a competing request is offered
      resp_ready = 1'b0;
      run_op("xor", 3'b010, 16'hAAAA, 16'h0F0F, 16'hA5A5, 1'b0, 1, 3'b011, 1'b0, 1'b0, 16'hAAAA, 16'h0F0F, 1'b0);
      req_valid = 1'b1;
      req_op    = 3'b011;
      req_a     = 16'h1111;
      req_b     = 16'h2222;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid", 64'(resp_valid), 64'd1);
         chk("bp_result", 64'(resp_result), 64'h0000_A5A5);
         chk("bp_ready", 64'(req_ready), 64'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      tick();
      chk("bp_done_valid", 64'(resp_valid), 64'd0);
      chk("bp_done_ready", 64'(req_ready), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_no_ghost", 64'({resp_valid, alu_bus()}), 64'd0);
      end

      run_op("ill", 3'b111, 16'h5555, 16'h3333, 16'h0000, 1'b1, 0, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

      // Reset in the middle of a multiply
      wait_ready("mulrst");
      req_valid = 1'b1;
      req_op    = 3'b110;
      req_a     = 16'h0013;
      req_b     = 16'h0011;
      tick();
      req_valid = 1'b0;
      repeat (8) tick();
      chk("mulrst_mid_op", 64'(alu_operation), 64'd4);
      chk("mulrst_mid_valid", 64'(resp_valid), 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mulrst_valid", 64'(resp_valid), 64'd0);
      chk("mulrst_alu", alu_bus(), 64'd0);
      chk("mulrst_ready", 64'(req_ready), 64'd0);
      tick();
      chk("mulrst_ready_after", 64'(req_ready), 64'd1);
      chk("mulrst_no_resp", 64'(resp_valid), 64'd0);

      run_op("and", 3'b000, 16'hFF00, 16'h0FF0, 16'h0F00, 1'b0, 1, 3'b000, 1'b0, 1'b0, 16'hFF00, 16'h0FF0, 1'b1);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
